pipelined_add_sub: RTL

Parametrised, pipelined successor to the 32-bit ripple adder/subtractor in the Kolache ALU. It computes add, subtract, add-with-carry and subtract-with-borrow on WIDTH-bit operands. The carry chain is split into STAGES registered segments, and it reports carry, overflow, zero and negative flags. Valid/ready handshakes on input and output let it sit between the operand-fetch and writeback stages with full backpressure.

---
 rtl/kolache_alu_pkg.sv | 27 ++
 rtl/add_sub_segment.sv | 29 ++
 rtl/pipelined_add_sub.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/kolache_alu_pkg.sv
// Kolache ALU shared definitions: opcodes, flag bit indices
// and the full-adder cell used by the arithmetic slices.
package kolache_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

    // returns {carry, sum}
    function automatic logic [1:0] fa(
        input logic x,
        input logic y,
        input logic ci
    );
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/add_sub_segment.sv
// Combinational SEG-bit ripple slice built from full-adder cells;
// one instance per pipeline stage.
module add_sub_segment
    import kolache_alu_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] bx,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           seg_zero
);

    logic c;

    always_comb begin
        c = cin;
        s = '0;
        for (int i = 0; i < SEG; i++) begin
            {c, s[i]} = fa(a[i], bx[i], c);
        end
    end

    assign cout     = c;
    assign seg_zero = ~|s;

endmodule

// File: rtl/pipelined_add_sub.sv
// Elastic add/sub pipeline: one carry segment per stage, skewed
// operands moving up, finished sum bits collecting below.
module pipelined_add_sub
    import kolache_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SEG = WIDTH / STAGES;

    logic [WIDTH-1:0]  bx;
    logic              carry0;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] ld;
    logic [STAGES:0]   ld_ext;

    assign bx = b ^ {WIDTH{op[0]}};

    always_comb begin
        carry0 = 1'b0;
        unique case (op_e'(op))
            OP_ADD:         carry0 = 1'b0;
            OP_SUB:         carry0 = 1'b1;
            OP_ADC, OP_SBB: carry0 = c_in;
            default:        carry0 = 1'b0;
        endcase
    end

    // a stage may load if it is empty or everything after it moves
    always_comb begin
        ld_ext         = '0;
        ld_ext[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld_ext[k] = !v[k] || ld_ext[k+1];
        end
    end

    assign ld        = ld_ext[STAGES-1:0];
    assign in_ready  = ld_ext[0];
    assign out_valid = v[STAGES-1];
    assign v_in      = STAGES'({v, in_valid});

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            v <= (v & ~ld) | (v_in & ld);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]    a_d;
        logic [REM-1:0]    bx_d;
        logic              c_d;
        logic              z_d;
        logic [SEG-1:0]    seg_s;
        logic              seg_c;
        logic              seg_z;
        logic [LO+SEG-1:0] s_n;
        logic [LO+SEG-1:0] s_q;

        if (k == 0) begin : g_in
            assign a_d  = a;
            assign bx_d = bx;
            assign c_d  = carry0;
            assign z_d  = 1'b1;
            assign s_n  = seg_s;
        end else begin : g_in
            assign a_d  = g_st[k-1].g_out.a_q;
            assign bx_d = g_st[k-1].g_out.bx_q;
            assign c_d  = g_st[k-1].g_out.c_q;
            assign z_d  = g_st[k-1].g_out.z_q;
            assign s_n  = {seg_s, g_st[k-1].s_q};
        end

        add_sub_segment #(
            .SEG(SEG)
        ) u_seg (
            .a       (a_d[SEG-1:0]),
            .bx      (bx_d[SEG-1:0]),
            .cin     (c_d),
            .s       (seg_s),
            .cout    (seg_c),
            .seg_zero(seg_z)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q <= '0;
            end else if (ld[k]) begin
                s_q <= s_n;
            end
        end

        if (k < STAGES - 1) begin : g_out
            localparam int HI = REM - SEG;

            logic [HI-1:0] a_q;
            logic [HI-1:0] bx_q;
            logic          c_q;
            logic          z_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                    c_q  <= 1'b0;
                    z_q  <= 1'b0;
                end else if (ld[k]) begin
                    a_q  <= a_d[REM-1:SEG];
                    bx_q <= bx_d[REM-1:SEG];
                    c_q  <= seg_c;
                    z_q  <= z_d & seg_z;
                end
            end
        end else begin : g_last
            logic [NUM_FLAGS-1:0] f_n;
            logic [NUM_FLAGS-1:0] f_q;

            always_comb begin
                f_n         = '0;
                f_n[FLAG_C] = seg_c;
                f_n[FLAG_V] = (a_d[SEG-1] == bx_d[SEG-1]) &&
                              (seg_s[SEG-1] != a_d[SEG-1]);
                f_n[FLAG_Z] = z_d & seg_z;
                f_n[FLAG_N] = seg_s[SEG-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    f_q <= '0;
                end else if (ld[k]) begin
                    f_q <= f_n;
                end
            end
        end
    end

    assign sum   = g_st[STAGES-1].s_q;
    assign c_out = g_st[STAGES-1].g_last.f_q[FLAG_C];
    assign ovf   = g_st[STAGES-1].g_last.f_q[FLAG_V];
    assign zero  = g_st[STAGES-1].g_last.f_q[FLAG_Z];
    assign neg   = g_st[STAGES-1].g_last.f_q[FLAG_N];

endmodule
